// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse key front end: FSM states, symbol limit and
// 7-segment glyphs ({dp,g,f,e,d,c,b,a}, active high).
package morse_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_e;

  localparam int unsigned SYM_MAX = 5;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_B = 8'h7C;
  localparam logic [7:0] SEG_C = 8'h39;
  localparam logic [7:0] SEG_D = 8'h5E;
  localparam logic [7:0] SEG_E = 8'h79;
  localparam logic [7:0] SEG_F = 8'h71;
  localparam logic [7:0] SEG_G = 8'h3D;
  localparam logic [7:0] SEG_H = 8'h76;
  localparam logic [7:0] SEG_I = 8'h30;
  localparam logic [7:0] SEG_J = 8'h1E;
  localparam logic [7:0] SEG_K = 8'h75;
  localparam logic [7:0] SEG_L = 8'h38;
  localparam logic [7:0] SEG_M = 8'h37;
  localparam logic [7:0] SEG_N = 8'h54;
  localparam logic [7:0] SEG_O = 8'h5C;
  localparam logic [7:0] SEG_P = 8'h73;
  localparam logic [7:0] SEG_Q = 8'h67;
  localparam logic [7:0] SEG_R = 8'h50;
  localparam logic [7:0] SEG_S = 8'h6D;
  localparam logic [7:0] SEG_T = 8'h78;
  localparam logic [7:0] SEG_U = 8'h3E;
  localparam logic [7:0] SEG_V = 8'h1C;
  localparam logic [7:0] SEG_W = 8'h2A;
  localparam logic [7:0] SEG_X = 8'h49;
  localparam logic [7:0] SEG_Y = 8'h6E;
  localparam logic [7:0] SEG_Z = 8'h5B;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse pattern decoder: {sym_len, sym_bits} -> {valid, 7-segment code}.
// Dash = 1, first symbol is the MSB of the sym_len valid bits; unused upper bits must be 0.
module morse_lut
  import morse_pkg::*;
(
  input  logic [2:0] sym_len,
  input  logic [4:0] sym_bits,
  output logic       valid,
  output logic [7:0] code
);

  always_comb begin
    valid = 1'b1;
    code  = SEG_BLANK;
    case ({sym_len, sym_bits})
      {3'd2, 5'b00001}: code = SEG_A;
      {3'd4, 5'b01000}: code = SEG_B;
      {3'd4, 5'b01010}: code = SEG_C;
      {3'd3, 5'b00100}: code = SEG_D;
      {3'd1, 5'b00000}: code = SEG_E;
      {3'd4, 5'b00010}: code = SEG_F;
      {3'd3, 5'b00110}: code = SEG_G;
      {3'd4, 5'b00000}: code = SEG_H;
      {3'd2, 5'b00000}: code = SEG_I;
      {3'd4, 5'b00111}: code = SEG_J;
      {3'd3, 5'b00101}: code = SEG_K;
      {3'd4, 5'b00100}: code = SEG_L;
      {3'd2, 5'b00011}: code = SEG_M;
      {3'd2, 5'b00010}: code = SEG_N;
      {3'd3, 5'b00111}: code = SEG_O;
      {3'd4, 5'b00110}: code = SEG_P;
      {3'd4, 5'b01101}: code = SEG_Q;
      {3'd3, 5'b00010}: code = SEG_R;
      {3'd3, 5'b00000}: code = SEG_S;
      {3'd1, 5'b00001}: code = SEG_T;
      {3'd3, 5'b00001}: code = SEG_U;
      {3'd4, 5'b00001}: code = SEG_V;
      {3'd3, 5'b00011}: code = SEG_W;
      {3'd4, 5'b01001}: code = SEG_X;
      {3'd4, 5'b01011}: code = SEG_Y;
      {3'd4, 5'b01100}: code = SEG_Z;
      {3'd5, 5'b11111}: code = SEG_0;
      {3'd5, 5'b01111}: code = SEG_1;
      {3'd5, 5'b00111}: code = SEG_2;
      {3'd5, 5'b00011}: code = SEG_3;
      {3'd5, 5'b00001}: code = SEG_4;
      {3'd5, 5'b00000}: code = SEG_5;
      {3'd5, 5'b10000}: code = SEG_6;
      {3'd5, 5'b11000}: code = SEG_7;
      {3'd5, 5'b11100}: code = SEG_8;
      {3'd5, 5'b11110}: code = SEG_9;
      default:          valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_entry.sv
// Morse key front end: times presses/gaps, collects up to five symbols and shifts the decoded
// 7-segment byte into a 64-bit buffer. Define MORSE_AUTOCOMMIT_EN to commit on a gap timeout.
module morse_entry
  import morse_pkg::*;
#(
  parameter int unsigned DASH_TICKS = 25_000_000,
  parameter int unsigned GAP_TICKS  = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_in,
  input  logic        commit,
  input  logic        clear,
  output logic [63:0] seg_buf,
  output logic [7:0]  char_code,
  output logic        char_valid,
  output logic        err,
  output logic [2:0]  sym_len
);

  localparam int unsigned PW = $clog2(DASH_TICKS) + 1;
  localparam logic [PW-1:0] DASH_LIM = PW'(DASH_TICKS);
  localparam logic [2:0] LEN_MAX = 3'(SYM_MAX);

  state_e        state_q, state_d;
  logic [PW-1:0] press_q, press_d;
  logic [4:0]    bits_q, bits_d;
  logic [2:0]    len_q, len_d;
  logic [63:0]   seg_q, seg_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          block_q, block_d;
  logic          timeout;
  logic          commit_now;
  logic          lut_valid;
  logic [7:0]    lut_code;

  morse_lut u_lut (
    .sym_len  (len_q),
    .sym_bits (bits_q),
    .valid    (lut_valid),
    .code     (lut_code)
  );

`ifdef MORSE_AUTOCOMMIT_EN
  localparam int unsigned GW = $clog2(GAP_TICKS) + 1;
  // The release edge is the first low cycle, so the last low cycle sees GAP_TICKS-2.
  localparam int unsigned GAP_LAST = (GAP_TICKS > 1) ? GAP_TICKS - 2 : 0;

  logic [GW-1:0] gap_q, gap_d;

  assign timeout = (state_q == GAP) && !key_in && (gap_q == GW'(GAP_LAST));

  // Counts only while idling low in GAP; any other path returns it to zero.
  always_comb begin
    gap_d = '0;
    if (!clear && (state_q == GAP) && !key_in && !commit && !timeout) begin
      gap_d = gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign commit_now = (state_q == GAP) && (commit || timeout);

  always_comb begin
    state_d = state_q;
    press_d = press_q;
    bits_d  = bits_q;
    len_d   = len_q;
    seg_d   = seg_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    block_d = block_q && key_in;

    if (clear) begin
      state_d = IDLE;
      press_d = '0;
      bits_d  = '0;
      len_d   = '0;
      seg_d   = '0;
      // A key held across clear must be released before it counts again.
      block_d = key_in;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_in && !block_q) begin
            state_d = PRESS;
            press_d = PW'(1);
          end
        end
        PRESS: begin
          if (key_in) begin
            if (press_q < DASH_LIM) begin
              press_d = press_q + 1'b1;
            end
          end else if (len_q < LEN_MAX) begin
            bits_d  = {bits_q[3:0], (press_q >= DASH_LIM)};
            len_d   = len_q + 1'b1;
            press_d = '0;
            state_d = GAP;
          end else begin
            err_d   = 1'b1;
            bits_d  = '0;
            len_d   = '0;
            press_d = '0;
            state_d = IDLE;
          end
        end
        GAP: begin
          if (commit_now) begin
            if (lut_valid) begin
              seg_d   = {seg_q[55:0], lut_code};
              code_d  = lut_code;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            bits_d  = '0;
            len_d   = '0;
            state_d = IDLE;
          end else if (key_in) begin
            press_d = PW'(1);
            state_d = PRESS;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      press_q <= '0;
      bits_q  <= '0;
      len_q   <= '0;
      seg_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      bits_q  <= bits_d;
      len_q   <= len_d;
      seg_q   <= seg_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      block_q <= block_d;
    end
  end

  assign seg_buf    = seg_q;
  assign char_code  = code_q;
  assign char_valid = valid_q;
  assign err        = err_q;
  assign sym_len    = len_q;

endmodule

// File: tb/tb_morse_entry.sv
// Self-checking bench for morse_entry: directed scenarios plus random keying, every cycle
// compared against a string/table-based reference model.
module tb_morse_entry;

  localparam int unsigned DASH = 4;
  localparam int unsigned GAPT = 8;
`ifdef MORSE_AUTOCOMMIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        key_in;
  logic        commit;
  logic        clear;
  logic [63:0] seg_buf;
  logic [7:0]  char_code;
  logic        char_valid;
  logic        err;
  logic [2:0]  sym_len;

  morse_entry #(
    .DASH_TICKS (DASH),
    .GAP_TICKS  (GAPT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .commit     (commit),
    .clear      (clear),
    .seg_buf    (seg_buf),
    .char_code  (char_code),
    .char_valid (char_valid),
    .err        (err),
    .sym_len    (sym_len)
  );

  always #5 clk = ~clk;

  string pats[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                      "..-", "...-", ".--", "-..-", "-.--", "--..",
                      "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                      "---..", "----."};
  logic [7:0] codes[36] = '{8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76, 8'h30,
                            8'h1E, 8'h75, 8'h38, 8'h37, 8'h54, 8'h5C, 8'h73, 8'h67, 8'h50,
                            8'h6D, 8'h78, 8'h3E, 8'h1C, 8'h2A, 8'h49, 8'h6E, 8'h5B,
                            8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F,
                            8'h6F};

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;

  // Reference model: symbols as a string, buffer as plain shifts.
  logic [63:0] m_buf;
  logic [7:0]  m_code;
  bit          m_valid, m_err, m_pressing, m_in_gap, m_blocked;
  string       m_syms;
  int          m_held, m_low;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input string p);
    for (int i = 0; i < 36; i++) begin
      if (pats[i] == p) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_buf = '0; m_code = '0; m_valid = 0; m_err = 0;
    m_pressing = 0; m_in_gap = 0; m_blocked = 0;
    m_syms = ""; m_held = 0; m_low = 0;
  endtask

  task automatic model_commit();
    int idx;
    idx = lookup(m_syms);
    if (idx >= 0) begin
      m_buf   = {m_buf[55:0], codes[idx]};
      m_code  = codes[idx];
      m_valid = 1;
    end else begin
      m_err = 1;
    end
    m_syms   = "";
    m_in_gap = 0;
  endtask

  task automatic model_step(input bit k, input bit c, input bit cl);
    m_valid = 0;
    m_err   = 0;
    if (cl) begin
      m_buf = '0; m_syms = ""; m_pressing = 0; m_in_gap = 0; m_blocked = k;
    end else if (m_blocked) begin
      m_blocked = k;
    end else if (m_pressing) begin
      if (k) begin
        m_held++;
      end else if (m_syms.len() < 5) begin
        m_syms     = {m_syms, (m_held >= DASH) ? "-" : "."};
        m_pressing = 0;
        m_in_gap   = 1;
        m_low      = 1;
      end else begin
        m_err      = 1;
        m_syms     = "";
        m_pressing = 0;
      end
    end else if (m_in_gap) begin
      if (c || (AUTO && !k && (m_low + 1 >= GAPT))) begin
        model_commit();
      end else if (k) begin
        m_in_gap = 0; m_pressing = 1; m_held = 1;
      end else begin
        m_low++;
      end
    end else if (k) begin
      m_pressing = 1;
      m_held     = 1;
    end
  endtask

  task automatic cycle(input bit k, input bit c, input bit cl);
    key_in = k; commit = c; clear = cl;
    @(posedge clk);
    model_step(k, c, cl);
    @(negedge clk);
    if (err) err_seen++;
    check("char_valid", char_valid, m_valid);
    check("err", err, m_err);
    check("sym_len", sym_len, 64'(m_syms.len()));
    check("seg_buf", seg_buf, m_buf);
    check("char_code", char_code, m_code);
  endtask

  task automatic press(input int n);
    repeat (n) cycle(1, 0, 0);
  endtask

  task automatic low(input int n);
    repeat (n) cycle(0, 0, 0);
  endtask

  task automatic end_char(input bit use_commit);
    if (AUTO && !use_commit) begin
      low(GAPT);
    end else begin
      low($urandom_range(1, GAPT - 1));
      cycle(0, 1, 0);
    end
  endtask

  task automatic send(input string p, input int dot_n, input int dash_n, input int gap_n,
                      input bit use_commit);
    byte ch;
    for (int i = 0; i < p.len(); i++) begin
      ch = p[i];
      press((ch == 8'h2D) ? dash_n : dot_n);
      if (i < p.len() - 1) low(gap_n);
    end
    end_char(use_commit);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " seg_buf"}, seg_buf, 64'h0);
    check({tag, " char_code"}, char_code, 64'h0);
    check({tag, " char_valid"}, char_valid, 64'h0);
    check({tag, " err"}, err, 64'h0);
    check({tag, " sym_len"}, sym_len, 64'h0);
  endtask

  initial begin
    int e0;
    rst = 1'b1; key_in = 1'b0; commit = 1'b0; clear = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // E: dot then a full gap
    press(2);
    low(1);
    check("E pending", sym_len, 64'd1);
    if (AUTO) low(GAPT - 1);
    else cycle(0, 1, 0);
    check("E valid", char_valid, 64'd1);
    check("E seg_buf", seg_buf, 64'h79);
    check("E sym_len", sym_len, 64'd0);

    // A: dot, gap 3, dash
    press(2); low(3); press(5); end_char(0);
    check("A code", char_code, 64'h77);
    check("A seg_buf", seg_buf, 64'h7977);

    // Six dots overflow
    repeat (5) begin press(2); low(2); end
    press(2);
    check("ovf pending", sym_len, 64'd5);
    low(1);
    check("ovf err", err, 64'd1);
    check("ovf sym_len", sym_len, 64'd0);
    check("ovf seg_buf", seg_buf, 64'h7977);
    low(2);

    // Unlisted pattern
    send("----", 2, 5, 2, 0);
    check("bad err", err, 64'd1);
    check("bad seg_buf", seg_buf, 64'h7977);

    // Nine T's: buffer wraps, no error
    e0 = err_seen;
    repeat (9) send("-", 2, 5, 2, 0);
    check("T seg_buf", seg_buf, {8{8'h78}});
    check("T no err", 64'(err_seen - e0), 64'd0);
    cycle(0, 0, 1);
    check("clear seg_buf", seg_buf, 64'h0);

    // Clear while key held: press ignored until release
    press(2);
    cycle(1, 0, 1);
    press(3);
    low(1);
    check("blocked sym_len", sym_len, 64'd0);
    low(GAPT);

    // Reset in PRESS with two symbols pending
    press(2); low(2); press(2); low(2); press(2);
    check("pre-rst sym_len", sym_len, 64'd2);
    rst = 1'b1; key_in = 1'b0;
    #1;
    check_reset_values("async rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send(".", 2, 5, 2, 0);
    check("post-rst seg_buf", seg_buf, 64'h79);

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 65) begin
        send(pats[$urandom_range(0, 35)], $urandom_range(1, 3), $urandom_range(4, 7),
             $urandom_range(1, 5), 1'($urandom_range(0, 1)));
      end else if (r < 90) begin
        repeat ($urandom_range(5, 40)) cycle(1'($urandom_range(0, 1)),
                                             ($urandom_range(0, 7) == 0), 0);
      end else if (r < 97) begin
        cycle(1'($urandom_range(0, 1)), 0, 1);
        low(2);
      end else begin
        rst = 1'b1; key_in = 1'b0; commit = 1'b0; clear = 1'b0;
        #1;
        check_reset_values("rand rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
